// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the MIPS monocycle core.
// Commits one of four next-PC candidates per enabled cycle and drives PC and
// PC+4 back to fetch. A small BOOT/RUN/HALT/FAULT state machine handles
// stalls, a halt/resume handshake and a sticky trap on misaligned targets.
// It also counts retired (committed) PC updates.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      branch_addr,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      jr_addr,
  input  logic             halt_req,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus_4,
  output logic [1:0]       state,
  output logic             fault,
  output logic [31:0]      fault_pc,
  output logic [31:0]      fault_target,
  output logic [CNT_W-1:0] retired
);

  // State encoding is visible on the state port, so it is fixed.
  localparam logic [1:0] ST_BOOT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  // The reset PC is always word-aligned, whatever the parameter's low bits are.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // A fetch target is legal only when it is word-aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  logic [1:0]       state_r;
  logic [31:0]      pc_r;
  logic             fault_r;
  logic [31:0]      fault_pc_r;
  logic [31:0]      fault_target_r;
  logic [CNT_W-1:0] retired_r;

  logic [1:0]       state_nx_s;
  logic [31:0]      pc_nx_s;
  logic             fault_nx_s;
  logic [31:0]      fault_pc_nx_s;
  logic [31:0]      fault_target_nx_s;
  logic [CNT_W-1:0] retired_nx_s;
  logic [31:0]      pc_plus_4_s;
  logic [31:0]      next_sel_s;

  // The increment wraps naturally at 2^32.
  assign pc_plus_4_s = pc_r + 32'd4;

  // Pick the next-PC candidate. Only this value is checked for alignment.
  always_comb begin
    next_sel_s = pc_plus_4_s;
    case (pc_src)
      2'b00:   next_sel_s = pc_plus_4_s;
      2'b01:   next_sel_s = branch_addr;
      2'b10:   next_sel_s = jump_target;
      2'b11:   next_sel_s = jr_addr;
      default: next_sel_s = pc_plus_4_s;
    endcase
  end

  // Sequencing FSM: decide next state, PC, trap capture and retire count.
  always_comb begin
    state_nx_s        = state_r;
    pc_nx_s           = pc_r;
    fault_pc_nx_s     = fault_pc_r;
    fault_target_nx_s = fault_target_r;
    retired_nx_s      = retired_r;
    case (state_r)
      ST_BOOT: begin
        // One settling cycle after reset. Inputs are ignored here.
        state_nx_s = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nx_s = ST_HALT;
        end else if (!en) begin
          state_nx_s = ST_RUN;
        end else if (!is_aligned(next_sel_s)) begin
          // Trap without committing, and keep the offending context for debug.
          state_nx_s        = ST_FAULT;
          fault_pc_nx_s     = pc_r;
          fault_target_nx_s = next_sel_s;
        end else begin
          pc_nx_s      = next_sel_s;
          retired_nx_s = retired_r + CNT_W'(1'b1);
        end
      end
      ST_HALT: begin
        // A resume that arrives together with halt_req loses to the halt.
        if (resume && !halt_req) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      ST_FAULT: begin
        // Sticky: only rst_n leaves this state.
        state_nx_s = ST_FAULT;
      end
      default: begin
        state_nx_s = ST_FAULT;
      end
    endcase
    fault_nx_s = (state_nx_s == ST_FAULT);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_BOOT;
      pc_r           <= RESET_PC_ALIGNED;
      fault_r        <= 1'b0;
      fault_pc_r     <= 32'h0000_0000;
      fault_target_r <= 32'h0000_0000;
      retired_r      <= '0;
    end else begin
      state_r        <= state_nx_s;
      pc_r           <= pc_nx_s;
      fault_r        <= fault_nx_s;
      fault_pc_r     <= fault_pc_nx_s;
      fault_target_r <= fault_target_nx_s;
      retired_r      <= retired_nx_s;
    end
  end

  assign pc           = pc_r;
  assign pc_plus_4    = pc_plus_4_s;
  assign state        = state_r;
  assign fault        = fault_r;
  assign fault_pc     = fault_pc_r;
  assign fault_target = fault_target_r;
  assign retired      = retired_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Two instances share every input. Instance A uses a 32-bit counter. Instance B
// uses a 4-bit counter and an unaligned RESET_PC, so its reset PC is masked.
module tb_pc_sequencer;

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;
  localparam logic [31:0] EXP_RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [1:0] pc_src = 2'b00;
  logic [31:0] branch_addr = 32'h0, jump_target = 32'h0, jr_addr = 32'h0;
  logic halt_req = 1'b0, resume = 1'b0;

  logic [31:0] pc_a, pc4_a, fpc_a, ftgt_a, retired_a;
  logic [1:0]  state_a;
  logic        fault_a;
  logic [31:0] pc_b, pc4_b, fpc_b, ftgt_b;
  logic [3:0]  retired_b;
  logic [1:0]  state_b;
  logic        fault_b;

  int checks = 0;
  int failures = 0;

  // Reference model state, in terms of what the block is defined to do.
  logic [1:0]  m_state;
  logic [31:0] m_pc, m_fpc, m_ftgt;
  int unsigned m_ret;

  pc_sequencer #(.RESET_PC(32'h0040_0000), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_src(pc_src),
    .branch_addr(branch_addr), .jump_target(jump_target), .jr_addr(jr_addr),
    .halt_req(halt_req), .resume(resume),
    .pc(pc_a), .pc_plus_4(pc4_a), .state(state_a), .fault(fault_a),
    .fault_pc(fpc_a), .fault_target(ftgt_a), .retired(retired_a)
  );

  pc_sequencer #(.RESET_PC(32'h0040_0003), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_src(pc_src),
    .branch_addr(branch_addr), .jump_target(jump_target), .jr_addr(jr_addr),
    .halt_req(halt_req), .resume(resume),
    .pc(pc_b), .pc_plus_4(pc4_b), .state(state_b), .fault(fault_b),
    .fault_pc(fpc_b), .fault_target(ftgt_b), .retired(retired_b)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = S_BOOT;
    m_pc = EXP_RST_PC;
    m_fpc = 32'h0;
    m_ftgt = 32'h0;
    m_ret = 0;
  endtask

  // Advance one rising edge. The model applies the rules to the inputs it sees.
  task automatic tick();
    logic [31:0] cand [4];
    logic [31:0] tgt;
    logic [1:0]  nst;
    logic [31:0] npc, nfpc, nftgt;
    int unsigned nret;
    cand[0] = m_pc + 32'd4;
    cand[1] = branch_addr;
    cand[2] = jump_target;
    cand[3] = jr_addr;
    nst = m_state; npc = m_pc; nfpc = m_fpc; nftgt = m_ftgt; nret = m_ret;
    if (m_state == S_BOOT) nst = S_RUN;
    else if (m_state == S_RUN) begin
      if (halt_req) nst = S_HALT;
      else if (en) begin
        tgt = cand[pc_src];
        if ((tgt % 32'd4) != 32'd0) begin
          nst = S_FAULT; nfpc = m_pc; nftgt = tgt;
        end else begin
          npc = tgt; nret = m_ret + 1;
        end
      end
    end else if (m_state == S_HALT) begin
      if (resume && !halt_req) nst = S_RUN;
    end
    @(posedge clk);
    #1;
    m_state = nst; m_pc = npc; m_fpc = nfpc; m_ftgt = nftgt; m_ret = nret;
  endtask

  // Pulse reset between edges. No clock edge occurs while it is low.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic quiet_inputs();
    en = 1'b1; pc_src = 2'b00; halt_req = 1'b0; resume = 1'b0;
    branch_addr = 32'h0; jump_target = 32'h0; jr_addr = 32'h0;
  endtask

  // Jump to an aligned address. The state machine must already be in RUN.
  task automatic goto_pc(input logic [31:0] addr);
    quiet_inputs();
    pc_src = 2'b10;
    jump_target = addr;
    tick();
    pc_src = 2'b00;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_a !== EXP_RST_PC) begin failures++; $display("FAIL reset_pc_a: got %h want %h", pc_a, EXP_RST_PC); end
    checks++; if (pc_b !== EXP_RST_PC) begin failures++; $display("FAIL reset_pc_b_masked: got %h want %h", pc_b, EXP_RST_PC); end
    checks++; if (state_a !== S_BOOT || fault_a !== 1'b0) begin failures++; $display("FAIL reset_state: got %b/%b want 00/0", state_a, fault_a); end
    checks++; if (fpc_a !== 32'h0 || ftgt_a !== 32'h0 || retired_a !== 32'h0) begin failures++; $display("FAIL reset_regs: got %h %h %h want 0", fpc_a, ftgt_a, retired_a); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (state_a !== S_RUN || pc_a !== EXP_RST_PC) begin failures++; $display("FAIL boot_hold: got %b %h want 01 %h", state_a, pc_a, EXP_RST_PC); end
    tick();
    checks++; if (pc_a !== 32'h0040_0004) begin failures++; $display("FAIL boot_step1: got %h want 00400004", pc_a); end
    tick();
    checks++; if (pc_a !== 32'h0040_0008 || retired_a !== 32'd2) begin failures++; $display("FAIL boot_step2: got %h/%0d want 00400008/2", pc_a, retired_a); end
    checks++; if (pc4_a !== 32'h0040_000C) begin failures++; $display("FAIL boot_pc4: got %h want 0040000c", pc4_a); end
    // Asynchronous reset in the middle of a clock period.
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (pc_a !== EXP_RST_PC || retired_a !== 32'h0 || state_a !== S_BOOT) begin failures++; $display("FAIL async_reset: got %h %0d %b want %h 0 00", pc_a, retired_a, state_a, EXP_RST_PC); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_source_select();
    logic [31:0] want;
    int unsigned r0;
    for (int k = 1; k < 4; k++) begin
      goto_pc(32'h0000_0100);
      r0 = m_ret;
      pc_src = 2'(k);
      // Unselected candidates are deliberately misaligned and must not trap.
      branch_addr = (k == 1) ? 32'h0000_0200 : 32'h0000_0203;
      jump_target = (k == 2) ? 32'h0000_0400 : 32'h0000_0401;
      jr_addr     = (k == 3) ? 32'h0000_0800 : 32'h0000_0802;
      want = (k == 1) ? 32'h200 : ((k == 2) ? 32'h400 : 32'h800);
      tick();
      checks++; if (pc_a !== want || state_a !== S_RUN) begin failures++; $display("FAIL src_%0d: got %h %b want %h 01", k, pc_a, state_a, want); end
      checks++; if (retired_a !== r0 + 1) begin failures++; $display("FAIL src_ret_%0d: got %0d want %0d", k, retired_a, r0 + 1); end
    end
  endtask

  task automatic test_stall_halt();
    int unsigned r0;
    goto_pc(32'h0000_0500);
    r0 = m_ret;
    en = 1'b0;
    repeat (3) tick();
    checks++; if (pc_a !== 32'h500 || retired_a !== r0) begin failures++; $display("FAIL stall: got %h/%0d want 500/%0d", pc_a, retired_a, r0); end
    en = 1'b1; halt_req = 1'b1;
    tick();
    checks++; if (state_a !== S_HALT || pc_a !== 32'h500) begin failures++; $display("FAIL halt_enter: got %b %h want 10 500", state_a, pc_a); end
    resume = 1'b1;
    tick();
    checks++; if (state_a !== S_HALT || pc_a !== 32'h500) begin failures++; $display("FAIL halt_both: got %b %h want 10 500", state_a, pc_a); end
    halt_req = 1'b0;
    tick();
    checks++; if (state_a !== S_RUN || pc_a !== 32'h500) begin failures++; $display("FAIL resume: got %b %h want 01 500", state_a, pc_a); end
    resume = 1'b0;
    tick();
    checks++; if (pc_a !== 32'h504 || retired_a !== r0 + 1) begin failures++; $display("FAIL resume_commit: got %h/%0d want 504/%0d", pc_a, retired_a, r0 + 1); end
  endtask

  task automatic test_fault();
    do_reset();
    quiet_inputs();
    tick();
    goto_pc(32'h0000_0300);
    pc_src = 2'b11; jr_addr = 32'h0000_0102;
    tick();
    checks++; if (state_a !== S_FAULT || fault_a !== 1'b1) begin failures++; $display("FAIL fault_enter: got %b/%b want 11/1", state_a, fault_a); end
    checks++; if (fpc_a !== 32'h300 || ftgt_a !== 32'h102 || pc_a !== 32'h300) begin failures++; $display("FAIL fault_capture: got %h %h %h want 300 102 300", fpc_a, ftgt_a, pc_a); end
    resume = 1'b1; en = 1'b1; pc_src = 2'b00;
    for (int i = 0; i < 4; i++) begin
      halt_req = 1'(i);
      tick();
    end
    checks++; if (state_a !== S_FAULT || pc_a !== 32'h300 || retired_a !== 32'd1 || ftgt_a !== 32'h102) begin failures++; $display("FAIL fault_sticky: got %b %h %0d %h want 11 300 1 102", state_a, pc_a, retired_a, ftgt_a); end
    do_reset();
    checks++; if (state_a !== S_BOOT || fault_a !== 1'b0 || pc_a !== EXP_RST_PC) begin failures++; $display("FAIL fault_reset: got %b %b %h want 00 0 %h", state_a, fault_a, pc_a, EXP_RST_PC); end
    checks++; if (fpc_a !== 32'h0 || ftgt_a !== 32'h0 || retired_a !== 32'h0) begin failures++; $display("FAIL fault_reset_regs: got %h %h %0d want 0 0 0", fpc_a, ftgt_a, retired_a); end
    quiet_inputs();
    tick();
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    checks++; if (pc4_a !== 32'h0) begin failures++; $display("FAIL wrap_pc4: got %h want 00000000", pc4_a); end
    tick();
    checks++; if (pc_a !== 32'h0 || pc_b !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h/%h want 00000000", pc_a, pc_b); end
    do_reset();
    quiet_inputs();
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        checks++; if (retired_b !== 4'd15) begin failures++; $display("FAIL cnt4_15: got %0d want 15", retired_b); end
      end
      if (i == 16) begin
        checks++; if (retired_b !== 4'd0 || retired_a !== 32'd16) begin failures++; $display("FAIL cnt4_wrap: got %0d/%0d want 0/16", retired_b, retired_a); end
      end
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 15) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      en = ($urandom_range(0, 3) != 0);
      pc_src = 2'($urandom_range(0, 3));
      branch_addr = rnd_addr(); jump_target = rnd_addr(); jr_addr = rnd_addr();
      halt_req = ($urandom_range(0, 5) == 0);
      resume = ($urandom_range(0, 1) == 0);
      tick();
      checks++; if (pc_a !== m_pc) begin failures++; $display("FAIL rand_pc_a: got %h want %h", pc_a, m_pc); end
      checks++; if (pc_b !== m_pc) begin failures++; $display("FAIL rand_pc_b: got %h want %h", pc_b, m_pc); end
      checks++; if (pc4_a !== m_pc + 32'd4) begin failures++; $display("FAIL rand_pc4: got %h want %h", pc4_a, m_pc + 32'd4); end
      checks++; if (state_a !== m_state || state_b !== m_state) begin failures++; $display("FAIL rand_state: got %b/%b want %b", state_a, state_b, m_state); end
      checks++; if (fault_a !== (m_state == S_FAULT)) begin failures++; $display("FAIL rand_fault: got %b want %b", fault_a, (m_state == S_FAULT)); end
      checks++; if (fpc_a !== m_fpc || ftgt_a !== m_ftgt) begin failures++; $display("FAIL rand_fregs: got %h %h want %h %h", fpc_a, ftgt_a, m_fpc, m_ftgt); end
      checks++; if (retired_a !== m_ret) begin failures++; $display("FAIL rand_ret_a: got %0d want %0d", retired_a, m_ret); end
      checks++; if (retired_b !== 4'(m_ret % 16)) begin failures++; $display("FAIL rand_ret_b: got %0d want %0d", retired_b, m_ret % 16); end
    end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_stall_halt();
    test_fault();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
